// File: rtl/wb_spram_pkg.sv
// wb_spram_pkg: shared types and helpers for the Wishbone single-port RAM controller
package wb_spram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RMW,
    RDACK,
    WRACK
  } state_t;

  function automatic logic [7:0] lane_merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       sel
  );
    return sel ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wb_spram_ctrl.sv
// wb_spram_ctrl: Wishbone classic slave fronting a synchronous single-port RAM, with read-modify-write for partial writes
module wb_spram_ctrl
  import wb_spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  ram_wren,
  output logic                  ram_cen
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   data_c;
  logic                    cen_c, wren_c;
  logic                    req;

  assign req = wb_cyc_i & wb_stb_i;

  for (genvar g = 0; g < SEL_WIDTH; g++) begin : g_lane
    assign merged[8*g +: 8] = lane_merge(ram_q[8*g +: 8], wb_dat_i[8*g +: 8], wb_sel_i[g]);
  end

  // next state, captured address and the RAM port request for this cycle
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cen_c   = 1'b0;
    wren_c  = 1'b0;
    data_c  = '0;
    case (state_q)
      IDLE: if (req) begin
        adr_d = wb_adr_i;
        if (!wb_we_i) begin
          cen_c   = 1'b1;
          state_d = RDACK;
        end else if (&wb_sel_i) begin
          cen_c   = 1'b1;
          wren_c  = 1'b1;
          data_c  = wb_dat_i;
          state_d = WRACK;
        end else if (~|wb_sel_i) begin
          state_d = WRACK;
        end else begin
          cen_c   = 1'b1;
          state_d = RMW;
        end
      end
      RMW: begin
        cen_c   = wb_cyc_i;
        wren_c  = wb_cyc_i;
        data_c  = wb_cyc_i ? merged : '0;
        state_d = wb_cyc_i ? WRACK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and address registers; async reset parks the FSM in IDLE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
    end
  end

  // every output is forced low while reset is asserted
  assign ram_cen     = reset_n & cen_c;
  assign ram_wren    = reset_n & wren_c;
  assign ram_data    = reset_n ? data_c : '0;
  assign ram_address = !reset_n ? '0 : (state_q == IDLE) ? wb_adr_i : adr_q;
  assign wb_ack_o    = reset_n & req & ((state_q == RDACK) | (state_q == WRACK));
  assign wb_dat_o    = (reset_n && state_q == RDACK) ? ram_q : '0;

endmodule
